// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot-time configuration sequencer.
// For each core it issues four writes over the cfg link: freeze, hart id,
// CCE id and CCE mode. It then unfreezes every core in turn and raises
// done_o. Every output is registered. Payloads are computed from the
// next state, so a new write is presented on the cycle right after a
// transfer and the link never sees a bubble.
module bp_cfg_loader #(
    parameter int num_core_p       = 1,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic                        cce_mode_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [cfg_core_width_p-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam logic [core_cnt_width_lp-1:0] last_core_lp = core_cnt_width_lp'(num_core_p - 1);

    localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] addr_hartid_lp = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] addr_cceid_lp  = cfg_addr_width_p'(16'h0003);
    localparam logic [cfg_addr_width_p-1:0] addr_mode_lp   = cfg_addr_width_p'(16'h0004);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_HARTID,
        S_CCEID,
        S_MODE,
        S_UNFREEZE,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [core_cnt_width_lp-1:0]  core_cnt_q, core_cnt_d;
    logic                          mode_q, mode_d;

    logic                          cfg_v_q, cfg_v_d;
    logic [cfg_core_width_p-1:0]   cfg_core_q, cfg_core_d;
    logic [cfg_addr_width_p-1:0]   cfg_addr_q, cfg_addr_d;
    logic [cfg_data_width_p-1:0]   cfg_data_q, cfg_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic xfer;
    logic last_core;
    logic active_d;

    assign xfer      = cfg_v_q & cfg_ready_i;
    assign last_core = (core_cnt_q == last_core_lp);

    // Next-state sequencing: walk the per-core write list, then the unfreeze pass.
    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        mode_d     = mode_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_FREEZE;
                    core_cnt_d = '0;
                    mode_d     = cce_mode_i;
                end
            end
            S_FREEZE: if (xfer) state_d = S_HARTID;
            S_HARTID: if (xfer) state_d = S_CCEID;
            S_CCEID:  if (xfer) state_d = S_MODE;
            S_MODE: begin
                if (xfer) begin
                    if (last_core) begin
                        core_cnt_d = '0;
                        state_d    = S_UNFREEZE;
                    end else begin
                        core_cnt_d = core_cnt_q + core_cnt_width_lp'(1);
                        state_d    = S_FREEZE;
                    end
                end
            end
            S_UNFREEZE: begin
                if (xfer) begin
                    if (last_core) begin
                        core_cnt_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        core_cnt_d = core_cnt_q + core_cnt_width_lp'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output payload for the write that the next state will present.
    always_comb begin
        active_d   = (state_d == S_FREEZE) || (state_d == S_HARTID) || (state_d == S_CCEID) ||
                     (state_d == S_MODE)   || (state_d == S_UNFREEZE);
        cfg_v_d    = active_d;
        busy_d     = active_d;
        done_d     = (state_d == S_DONE);
        cfg_core_d = active_d ? cfg_core_width_p'(core_cnt_d) : '0;
        cfg_addr_d = '0;
        cfg_data_d = '0;
        case (state_d)
            S_FREEZE: begin
                cfg_addr_d = addr_freeze_lp;
                cfg_data_d = cfg_data_width_p'(1'b1);
            end
            S_HARTID: begin
                cfg_addr_d = addr_hartid_lp;
                cfg_data_d = cfg_data_width_p'(core_cnt_d);
            end
            S_CCEID: begin
                cfg_addr_d = addr_cceid_lp;
                cfg_data_d = cfg_data_width_p'(core_cnt_d);
            end
            S_MODE: begin
                cfg_addr_d = addr_mode_lp;
                cfg_data_d = cfg_data_width_p'(mode_d);
            end
            S_UNFREEZE: begin
                cfg_addr_d = addr_freeze_lp;
                cfg_data_d = '0;
            end
            default: begin
                cfg_addr_d = '0;
                cfg_data_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            core_cnt_q <= '0;
            mode_q     <= 1'b0;
            cfg_v_q    <= 1'b0;
            cfg_core_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            mode_q     <= mode_d;
            cfg_v_q    <= cfg_v_d;
            cfg_core_q <= cfg_core_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_v_o    = cfg_v_q;
    assign cfg_core_o = cfg_core_q;
    assign cfg_addr_o = cfg_addr_q;
    assign cfg_data_o = cfg_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // Core count must be addressable by the core-select field.
    a_num_core: assert property (@(posedge clk_i)
        (num_core_p >= 1) && (num_core_p <= (2 ** cfg_core_width_p)));

    // The link ready must be a known value whenever we are out of reset.
    a_ready_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !$isunknown(cfg_ready_i));

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Testbench for bp_cfg_loader: two instances (2 cores and 1 core) share a
// clock and reset. Stimulus pushes the expected write list into a per-instance
// queue when it issues a start; a negedge monitor pops and compares on every
// transfer and checks the hold-until-transfer handshake.
module tb_bp_cfg_loader;

    typedef struct packed {
        logic [7:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_s [2];
    logic        mode_s  [2];
    logic        ready_s [2];
    logic        v_s     [2];
    logic [7:0]  core_s  [2];
    logic [15:0] addr_s  [2];
    logic [63:0] data_s  [2];
    logic        busy_s  [2];
    logic        done_s  [2];

    exp_t q0[$];
    exp_t q1[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    int   t_acc [2];
    int   n_xfer [2];
    logic rnd [2];
    logic pend [2];
    exp_t pend_val [2];

    bp_cfg_loader #(.num_core_p(2)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_s[0]), .cce_mode_i(mode_s[0]),
        .cfg_v_o(v_s[0]), .cfg_ready_i(ready_s[0]), .cfg_core_o(core_s[0]),
        .cfg_addr_o(addr_s[0]), .cfg_data_o(data_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0])
    );

    bp_cfg_loader #(.num_core_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_s[1]), .cce_mode_i(mode_s[1]),
        .cfg_v_o(v_s[1]), .cfg_ready_i(ready_s[1]), .cfg_core_o(core_s[1]),
        .cfg_addr_o(addr_s[1]), .cfg_data_o(data_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Reference model: the full write list for one start, from the register map.
    function automatic void push_seq(int i, int ncore, logic m);
        exp_t e;
        for (int c = 0; c < ncore; c++) begin
            e = '{core: 8'(c), addr: 16'd1, data: 64'd1};        if (i == 0) q0.push_back(e); else q1.push_back(e);
            e = '{core: 8'(c), addr: 16'd2, data: 64'(c)};       if (i == 0) q0.push_back(e); else q1.push_back(e);
            e = '{core: 8'(c), addr: 16'd3, data: 64'(c)};       if (i == 0) q0.push_back(e); else q1.push_back(e);
            e = '{core: 8'(c), addr: 16'd4, data: 64'(m)};       if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int c = 0; c < ncore; c++) begin
            e = '{core: 8'(c), addr: 16'd1, data: 64'd0};
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    endfunction

    // Monitor: compare each transfer with the scoreboard and check handshake hold.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t cur;
            exp_t e;
            cur = '{core: core_s[i], addr: addr_s[i], data: data_s[i]};
            if (!rst_n) begin
                pend[i] = 1'b0;
            end else begin
                chk($sformatf("done_busy_excl%0d", i), 128'(done_s[i] & busy_s[i]), 128'd0);
                if (pend[i]) begin
                    chk($sformatf("hold_v%0d", i), 128'(v_s[i]), 128'd1);
                    chk($sformatf("hold_payload%0d", i), 128'(cur), 128'(pend_val[i]));
                end
                if (v_s[i] && ready_s[i]) begin
                    n_xfer[i]++;
                    if (qsize(i) == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write%0d: got %0h expected no write", i, cur);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("write%0d", i), 128'(cur), 128'(e));
                    end
                    pend[i] = 1'b0;
                end else if (v_s[i]) begin
                    pend[i]     = 1'b1;
                    pend_val[i] = cur;
                end else begin
                    pend[i] = 1'b0;
                end
            end
        end
    end

    // Random ready generator for instances in random-backpressure mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (rnd[i]) ready_s[i] = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_start(input int i, input logic m);
        @(posedge clk);
        #1;
        push_seq(i, (i == 0) ? 2 : 1, m);
        start_s[i] = 1'b1;
        mode_s[i]  = m;
        @(posedge clk);
        #1;
        start_s[i] = 1'b0;
        t_acc[i]   = edge_cnt;
        chk("v_after_start", 128'(v_s[i]), 128'd1);
        chk("busy_after_start", 128'(busy_s[i]), 128'd1);
        chk("done_cleared", 128'(done_s[i]), 128'd0);
    endtask

    task automatic wait_done(input int i, input int exp_cyc, input string name);
        int lim;
        lim = 0;
        while (!done_s[i] && lim < 400) begin
            @(posedge clk);
            #1;
            lim++;
        end
        if (!done_s[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: done never rose within %0d cycles", name, lim);
        end else if (exp_cyc >= 0) begin
            chk({name, "_latency"}, 128'(edge_cnt - t_acc[i]), 128'(exp_cyc));
        end
        chk({name, "_sb_empty"}, 128'(qsize(i)), 128'd0);
        chk({name, "_busy_low"}, 128'(busy_s[i]), 128'd0);
    endtask

    initial begin
        logic m;
        int   base;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; mode_s[i] = 1'b0; ready_s[i] = 1'b1;
            rnd[i] = 1'b0; pend[i] = 1'b0; n_xfer[i] = 0; t_acc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_v", 128'(v_s[i]), 128'd0);
            chk("reset_busy", 128'(busy_s[i]), 128'd0);
            chk("reset_done", 128'(done_s[i]), 128'd0);
            chk("reset_payload", 128'({core_s[i], addr_s[i], data_s[i]}), 128'd0);
        end
        rst_n = 1'b1;

        // Two cores, mode 1, ready high: ten back-to-back writes.
        base = n_xfer[0];
        do_start(0, 1'b1);
        wait_done(0, 10, "basic");
        chk("basic_xfers", 128'(n_xfer[0] - base), 128'd10);
        $display("txn basic: done after %0d cycles", edge_cnt - t_acc[0]);

        // Backpressure during HARTID of core 1 delays done by three cycles.
        do_start(0, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        ready_s[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_hold_v", 128'(v_s[0]), 128'd1);
        chk("bp_hold_payload", 128'({core_s[0], addr_s[0], data_s[0]}),
            128'({8'd1, 16'd2, 64'd1}));
        @(posedge clk); #1;
        ready_s[0] = 1'b1;
        wait_done(0, 13, "backpressure");
        $display("txn backpressure: done after %0d cycles", edge_cnt - t_acc[0]);

        // Start pulsed mid-sequence with a different mode is ignored.
        base = n_xfer[0];
        do_start(0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        start_s[0] = 1'b1;
        mode_s[0]  = 1'b0;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_done(0, 10, "busy_start");
        chk("busy_start_xfers", 128'(n_xfer[0] - base), 128'd10);
        $display("txn busy_start: %0d writes", n_xfer[0] - base);

        // Reset while MODE of core 0 is presented aborts the sequence.
        do_start(0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_at_mode", 128'(addr_s[0]), 128'd4);
        rst_n      = 1'b0;
        ready_s[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_v", 128'(v_s[0]), 128'd0);
        chk("abort_busy", 128'(busy_s[0]), 128'd0);
        chk("abort_done", 128'(done_s[0]), 128'd0);
        q0.delete();
        q1.delete();
        rst_n      = 1'b1;
        ready_s[0] = 1'b1;
        do_start(0, 1'b1);
        wait_done(0, 10, "replay");
        $display("txn reset_replay: done after %0d cycles", edge_cnt - t_acc[0]);

        // Restart from DONE with mode 0, then random modes, under random ready.
        rnd[0] = 1'b1;
        do_start(0, 1'b0);
        wait_done(0, -1, "restart_mode0");
        $display("txn restart_mode0: done after %0d cycles", edge_cnt - t_acc[0]);
        for (int k = 0; k < 4; k++) begin
            m = 1'($urandom_range(0, 1));
            do_start(0, m);
            wait_done(0, -1, "rand2");
            $display("txn rand2 mode=%0d: done after %0d cycles", m, edge_cnt - t_acc[0]);
        end
        rnd[0] = 1'b0;
        ready_s[0] = 1'b1;

        // Single core under random ready: exactly five writes, done sticky.
        rnd[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            base = n_xfer[1];
            m = 1'($urandom_range(0, 1));
            do_start(1, m);
            wait_done(1, -1, "single");
            chk("single_xfers", 128'(n_xfer[1] - base), 128'd5);
            repeat (6) begin @(posedge clk); #1; end
            chk("single_done_sticky", 128'(done_s[1]), 128'd1);
            chk("single_idle_v", 128'(v_s[1]), 128'd0);
            $display("txn single mode=%0d: %0d writes", m, n_xfer[1] - base);
        end
        rnd[1] = 1'b0;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
